// File: rtl/fcb_2_skid_registered_rdy.sv
// Two-slot valid/ready pipeline register (output + skid slot).
// All outputs, up_rdy included, come straight from flops.
module fcb_2_skid_registered_rdy #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [w-1:0] up_data,
  output logic         down_vld,
  input  logic         down_rdy,
  output logic [w-1:0] down_data
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   st_q;
  logic [1:0]   st_d;
  logic         up_rdy_q;
  logic         down_vld_q;
  logic [w-1:0] out_q;
  logic [w-1:0] skid_q;
  logic         load_out;
  logic         load_skid;
  logic         out_from_skid;

  always_comb begin
    st_d          = st_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    unique case (st_q)
      EMPTY: begin
        if (up_vld) begin
          load_out = 1'b1;
          st_d     = BUSY;
        end
      end
      BUSY: begin
        if (up_vld && down_rdy) begin
          load_out = 1'b1;
        end else if (up_vld) begin
          load_skid = 1'b1;
          st_d      = FULL;
        end else if (down_rdy) begin
          st_d = EMPTY;
        end
      end
      FULL: begin
        // up_rdy is low here, so any upstream offer is ignored
        if (down_rdy) begin
          load_out      = 1'b1;
          out_from_skid = 1'b1;
          st_d          = BUSY;
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= EMPTY;
      up_rdy_q   <= 1'b1;
      down_vld_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      up_rdy_q   <= (st_d != FULL);
      down_vld_q <= (st_d != EMPTY);
    end
  end

  // Payload slots carry no reset; down_data is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_q <= out_from_skid ? skid_q : up_data;
    end
    if (load_skid) begin
      skid_q <= up_data;
    end
  end

  assign up_rdy    = up_rdy_q;
  assign down_vld  = down_vld_q;
  assign down_data = out_q;

endmodule

// File: tb/tb_fcb_2_skid_registered_rdy.sv
// Directed and scoreboarded random checks for the two-slot
// registered-ready pipeline register.
module tb_fcb_2_skid_registered_rdy;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         up_vld;
  logic         up_rdy;
  logic [W-1:0] up_data;
  logic         down_vld;
  logic         down_rdy;
  logic [W-1:0] down_data;

  int n_cmp;
  int n_err;

  fcb_2_skid_registered_rdy #(.w(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .up_vld   (up_vld),
    .up_rdy   (up_rdy),
    .up_data  (up_data),
    .down_vld (down_vld),
    .down_rdy (down_rdy),
    .down_data(down_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    up_vld   = 1'b0;
    up_data  = '0;
    down_rdy = 1'b0;
    #1;
    n_cmp++;
    if (up_rdy !== 1'b1 || down_vld !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: rdy=%b vld=%b want rdy=1 vld=0",
               up_rdy, down_vld);
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (up_rdy !== 1'b1 || down_vld !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b vld=%b want rdy=1 vld=0",
               up_rdy, down_vld);
    end
  endtask

  task automatic test_reset_mid_full();
    down_rdy = 1'b0;
    up_vld   = 1'b1;
    up_data  = 8'h11;
    step();
    up_data = 8'h22;
    step();
    up_vld = 1'b0;
    n_cmp++;
    if (up_rdy !== 1'b0 || down_vld !== 1'b1 || down_data !== 8'h11) begin
      n_err++;
      $display("FAIL rstfull_fill: rdy=%b vld=%b data=%h want 0 1 11",
               up_rdy, down_vld, down_data);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (up_rdy !== 1'b1 || down_vld !== 1'b0) begin
      n_err++;
      $display("FAIL rstfull_async: rdy=%b vld=%b want rdy=1 vld=0",
               up_rdy, down_vld);
    end
    #1;
    rst      = 1'b0;
    down_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (down_vld !== 1'b0) begin
        n_err++;
        $display("FAIL rstfull_stale: cyc=%0d vld=%b data=%h want vld=0",
                 i, down_vld, down_data);
      end
    end
  endtask

  task automatic test_stream();
    down_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      up_vld  = 1'b1;
      up_data = 8'(i + 1);
      step();
      n_cmp++;
      if (down_vld !== 1'b1 || down_data !== 8'(i + 1)
          || up_rdy !== 1'b1) begin
        n_err++;
        $display("FAIL stream: i=%0d vld=%b data=%h rdy=%b want 1 %h 1",
                 i, down_vld, down_data, up_rdy, 8'(i + 1));
      end
    end
    up_vld = 1'b0;
    step();
    n_cmp++;
    if (down_vld !== 1'b0 || up_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL stream_end: vld=%b rdy=%b want vld=0 rdy=1",
               down_vld, up_rdy);
    end
  endtask

  task automatic test_backpressure();
    down_rdy = 1'b0;
    up_vld   = 1'b1;
    up_data  = 8'h11;
    step();
    n_cmp++;
    if (up_rdy !== 1'b1 || down_vld !== 1'b1 || down_data !== 8'h11) begin
      n_err++;
      $display("FAIL bp_first: rdy=%b vld=%b data=%h want 1 1 11",
               up_rdy, down_vld, down_data);
    end
    up_data = 8'h22;
    step();
    n_cmp++;
    if (up_rdy !== 1'b0 || down_vld !== 1'b1 || down_data !== 8'h11) begin
      n_err++;
      $display("FAIL bp_full: rdy=%b vld=%b data=%h want 0 1 11",
               up_rdy, down_vld, down_data);
    end
    up_data = 8'h33;
    step();
    n_cmp++;
    if (up_rdy !== 1'b0 || down_data !== 8'h11) begin
      n_err++;
      $display("FAIL bp_hold: rdy=%b data=%h want rdy=0 data=11",
               up_rdy, down_data);
    end
    down_rdy = 1'b1;
    step();
    up_vld = 1'b0;
    n_cmp++;
    if (up_rdy !== 1'b1 || down_vld !== 1'b1 || down_data !== 8'h22) begin
      n_err++;
      $display("FAIL bp_release: rdy=%b vld=%b data=%h want 1 1 22",
               up_rdy, down_vld, down_data);
    end
    step();
    n_cmp++;
    if (down_vld !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_33: vld=%b data=%h want vld=0",
               down_vld, down_data);
    end
  endtask

  task automatic test_path_cut();
    down_rdy = 1'b0;
    up_vld   = 1'b1;
    up_data  = 8'h5A;
    step();
    up_vld = 1'b0;
    #1;
    down_rdy = 1'b1;
    up_vld   = 1'b1;
    up_data  = 8'hFF;
    #1;
    n_cmp++;
    if (up_rdy !== 1'b1 || down_vld !== 1'b1 || down_data !== 8'h5A) begin
      n_err++;
      $display("FAIL cut_busy: rdy=%b vld=%b data=%h want 1 1 5a",
               up_rdy, down_vld, down_data);
    end
    down_rdy = 1'b0;
    up_data  = 8'h6B;
    step();
    up_vld = 1'b0;
    n_cmp++;
    if (up_rdy !== 1'b0 || down_data !== 8'h5A) begin
      n_err++;
      $display("FAIL cut_fill: rdy=%b data=%h want rdy=0 data=5a",
               up_rdy, down_data);
    end
    #1;
    down_rdy = 1'b1;
    #1;
    n_cmp++;
    if (up_rdy !== 1'b0 || down_vld !== 1'b1 || down_data !== 8'h5A) begin
      n_err++;
      $display("FAIL cut_full: rdy=%b vld=%b data=%h want 0 1 5a",
               up_rdy, down_vld, down_data);
    end
    step();
    n_cmp++;
    if (up_rdy !== 1'b1 || down_data !== 8'h6B) begin
      n_err++;
      $display("FAIL cut_drain: rdy=%b data=%h want rdy=1 data=6b",
               up_rdy, down_data);
    end
    step();
  endtask

  task automatic test_drain();
    down_rdy = 1'b1;
    up_vld   = 1'b1;
    up_data  = 8'hA5;
    step();
    up_vld = 1'b0;
    n_cmp++;
    if (down_vld !== 1'b1 || down_data !== 8'hA5) begin
      n_err++;
      $display("FAIL drain_beat: vld=%b data=%h want vld=1 data=a5",
               down_vld, down_data);
    end
    step();
    n_cmp++;
    if (down_vld !== 1'b0 || up_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL drain_empty: vld=%b rdy=%b want vld=0 rdy=1",
               down_vld, up_rdy);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic         hold;
    logic [W-1:0] hold_data;
    int           bad;
    bad  = 0;
    hold = 1'b0;
    hold_data = '0;
    for (int c = 0; c < 10020; c++) begin
      n_cmp++;
      if (down_vld !== (q.size() != 0) || up_rdy !== (q.size() < 2)
          || (q.size() != 0 && down_data !== q[0])
          || (hold && down_data !== hold_data)) begin
        n_err++;
        bad++;
        if (bad <= 5) begin
          $display("FAIL random: c=%0d vld=%b rdy=%b data=%h want vld=%b rdy=%b data=%h",
                   c, down_vld, up_rdy, down_data, q.size() != 0,
                   q.size() < 2, (q.size() != 0) ? q[0] : 8'h00);
        end
      end
      if (c < 10000) begin
        up_vld   = ($urandom_range(0, 99) < 50);
        down_rdy = ($urandom_range(0, 99) < 30);
        up_data  = 8'($urandom);
      end else begin
        up_vld   = 1'b0;
        down_rdy = 1'b1;
      end
      hold      = down_vld && !down_rdy;
      hold_data = down_data;
      if (down_vld && down_rdy && q.size() != 0) begin
        void'(q.pop_front());
      end
      if (up_vld && up_rdy) begin
        q.push_back(up_data);
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_reset_mid_full();
    test_stream();
    test_backpressure();
    test_path_cut();
    test_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
